// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - six-digit multiplexed seven-segment scanner with frame snapshot, blink, blanking and dots
module seg_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic [5:0]  blink_mask,
    input  logic        lz_blank,
    input  logic        dots_en,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [23:0]   shd;
    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic          load_pend;

    logic          tick;
    logic          frame_end;
    logic          dead;
    logic [3:0]    digit;
    logic [6:0]    glyph;
    logic          blanked;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign tick      = (div == DIV_LAST);
    assign frame_end = tick && (idx == 3'd5);
    assign dead      = (div == '0);

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = shd[3:0];
            3'd1:    digit = shd[7:4];
            3'd2:    digit = shd[11:8];
            3'd3:    digit = shd[15:12];
            3'd4:    digit = shd[19:16];
            3'd5:    digit = shd[23:20];
            default: digit = 4'd0;
        endcase
    end

    // Segment order is {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    always_comb begin
        glyph = 7'b1000000;
        case (digit)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b1000000;
        endcase
    end

    always_comb begin
        blanked  = (blink_mask[idx] && phase) ||
                   ((idx == 3'd5) && lz_blank && (digit == 4'd0));
        an_next  = 6'b111111;
        seg_next = 7'b0000000;
        dp_next  = 1'b0;
        // The first cycle of every slot is dark so the previous digit cannot ghost.
        if (!dead) begin
            an_next  = ~(6'b000001 << idx);
            seg_next = blanked ? 7'b0000000 : glyph;
            dp_next  = dots_en && ((idx == 3'd2) || (idx == 3'd4)) && !blanked;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            idx       <= 3'd0;
            shd       <= 24'h000000;
            frame_cnt <= '0;
            phase     <= 1'b0;
            load_pend <= 1'b1;
            an        <= 6'b111111;
            seg       <= 7'b0000000;
            dp        <= 1'b0;
        end else if (load_pend) begin
            // First edge after reset only captures the time; scanning starts next edge.
            shd       <= time_bcd;
            load_pend <= 1'b0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (frame_end) begin
                shd <= time_bcd;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
